// File: rtl/per_uart.sv
// per_uart: transmit-only UART slave on the xSimBus device bus.
//   Register map (addr_in[3:2]): 0 CTRL, 1 STATUS, 2 TXDATA, 3 BAUD_DIV.
//   Bytes written to TXDATA are queued in a FIFO and sent as 8N1 frames.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   select_as_in      bus selection mode; accesses only when SelectAsDevice
//   addr_in/data_in   byte address / write data from the bus
//   rw_in             RWInoutW = write, RWInoutR = read
//   data_out          combinational read data (ZeroWord when not reading)
//   tx_out            registered serial line, idles high
//   irq_out           registered level interrupt: TX drained (irq_en & empty & ~busy)

package per_uart_pkg;
   typedef enum logic [1:0] {
      SelectAsNone   = 2'd0,
      SelectAsDevice = 2'd1,
      SelectAsMemory = 2'd2
   } SelectModeBus;
   typedef enum logic {RWInoutR = 1'b0, RWInoutW = 1'b1} RWInout;
   localparam logic [31:0] ZeroWord = 32'h0;
endpackage

module per_uart
   import per_uart_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic         clk,
   input  logic         rst,
   input  SelectModeBus select_as_in,
   input  logic [31:0]  addr_in,
   input  logic [31:0]  data_in,
   output logic [31:0]  data_out,
   input  logic         rw_in,
   output logic         tx_out,
   output logic         irq_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_d;
   logic          tx_en, irq_en, ovf;
   logic [15:0]   div;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] fifo_cnt;
   logic [3:0]    cnt4;
   logic [15:0]   bit_cnt, cnt_d;
   logic [2:0]    idx, idx_d;
   logic [7:0]    shift, shift_d;
   logic          tx_d;
   logic          wr_en, rd_en, push, pop, accept, full, empty, busy, bit_end;
   logic [1:0]    reg_sel;
   logic          unused_bits;

   assign unused_bits = ^{addr_in[31:4], addr_in[1:0], data_in[31:16]};

   assign reg_sel = addr_in[3:2];
   assign wr_en   = (select_as_in == SelectAsDevice) && (rw_in == RWInoutW);
   assign rd_en   = (select_as_in == SelectAsDevice) && (rw_in == RWInoutR);
   assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
   assign empty   = (fifo_cnt == '0);
   assign busy    = (state != IDLE);
   assign bit_end = (bit_cnt == 16'd0);
   assign push    = wr_en && (reg_sel == 2'd2);
   assign pop     = (state == IDLE) && tx_en && !empty;
   // A push into a full FIFO is still accepted when the FSM frees a slot on the same edge.
   assign accept  = push && (!full || pop);
   assign cnt4    = 4'(fifo_cnt);

   // ---------------- control registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_en  <= 1'b0;
         irq_en <= 1'b0;
         div    <= DEFAULT_DIV;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) begin
            case (reg_sel)
               2'd0: begin
                  tx_en  <= data_in[0];
                  irq_en <= data_in[1];
               end
               2'd1: if (data_in[3]) ovf <= 1'b0;
               2'd3: div <= data_in[15:0];
               default: ;
            endcase
         end
         if (push && full && !pop) ovf <= 1'b1;
      end
   end

   // ---------------- TX FIFO ----------------
   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= data_in[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else begin
         if (accept) wptr <= wptr + 1'b1;
         if (pop)    rptr <= rptr + 1'b1;
         case ({accept, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (pop) state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && idx == 3'd7) state_d = STOP;
         STOP:  if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath ----------------
   // Bit counter reloads from the live div at each bit start, so BAUD_DIV
   // changes apply from the next bit boundary.
   always_comb begin
      cnt_d   = bit_cnt;
      idx_d   = idx;
      shift_d = shift;
      if (state == IDLE) begin
         if (pop) begin
            shift_d = mem[rptr];
            cnt_d   = div;
            idx_d   = 3'd0;
         end
      end else if (bit_end) begin
         cnt_d = div;
         if (state == DATA) begin
            shift_d = shift >> 1;
            idx_d   = idx + 3'd1;
         end
      end else begin
         cnt_d = bit_cnt - 16'd1;
      end
      // tx_out is registered from the next state so the line changes right after the edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         idx     <= '0;
         shift   <= '0;
         tx_out  <= 1'b1;
         irq_out <= 1'b0;
      end else begin
         bit_cnt <= cnt_d;
         idx     <= idx_d;
         shift   <= shift_d;
         tx_out  <= tx_d;
         irq_out <= irq_en & empty & ~busy;
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      data_out = ZeroWord;
      if (rd_en) begin
         case (reg_sel)
            2'd0:    data_out = {30'd0, irq_en, tx_en};
            2'd1:    data_out = {24'd0, cnt4, ovf, empty, full, busy};
            2'd3:    data_out = {16'd0, div};
            default: data_out = ZeroWord;
         endcase
      end
   end

endmodule

// File: tb/tb_per_uart.sv
module tb_per_uart;
   import per_uart_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   SelectModeBus sel = SelectAsNone;
   logic [31:0]  addr = '0;
   logic [31:0]  wdata = '0;
   logic         rw = 1'b0;
   logic [31:0]  data_out;
   logic         tx_out, irq_out;

   per_uart #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst(rst), .select_as_in(sel), .addr_in(addr), .data_in(wdata),
      .data_out(data_out), .rw_in(rw), .tx_out(tx_out), .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int cur_div = 3;
   bit mon_en = 1'b0;

   typedef struct {
      logic [7:0] d;
      int         gap;       // expected start-to-start distance, -1 = don't care
      int         start_at;  // expected cyc value at first low sample, -1 = don't care
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = SelectAsDevice; addr = {28'd0, a, 2'b00}; wdata = d; rw = 1'b1;
      @(posedge clk);
      #1;
      sel = SelectAsNone; rw = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = SelectAsDevice; addr = {28'd0, a, 2'b00}; rw = 1'b0;
      #1 d = data_out;
      sel = SelectAsNone;
   endtask

   task automatic expect_byte(input logic [7:0] d, input int gap, input int start_at);
      exp_t e;
      e.d = d; e.gap = gap; e.start_at = start_at;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) fail_msg("drain_timeout");
      repeat (4) @(negedge clk);
   endtask

   // Monitor: decodes frames on tx_out by mid-bit sampling and scores them.
   initial begin : monitor
      int t0;
      int last_start;
      logic [7:0] rx;
      exp_t e;
      last_start = 0;
      forever begin
         @(negedge clk);
         if (mon_en && rst === 1'b0 && tx_out === 1'b0) begin
            t0 = cyc;
            repeat (cur_div / 2) @(negedge clk);
            check("start_bit", {31'd0, tx_out}, 32'd0);
            for (int k = 0; k < 8; k++) begin
               repeat (cur_div + 1) @(negedge clk);
               rx[k] = tx_out;
            end
            repeat (cur_div + 1) @(negedge clk);
            check("stop_bit", {31'd0, tx_out}, 32'd1);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: got 0x%0h expected no frame", rx);
            end else begin
               e = sb.pop_front();
               check("rx_byte", {24'd0, rx}, {24'd0, e.d});
               if (e.gap >= 0) check("frame_gap", t0 - last_start, e.gap);
               if (e.start_at >= 0) check("start_latency", t0, e.start_at);
            end
            last_start = t0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] r;
      int c0;
      bit done;

      // ---- reset values ----
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tx", {31'd0, tx_out}, 32'd1);
      check("rst_irq", {31'd0, irq_out}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      rst = 1'b0;
      bus_rd(2'd1, r); check("rst_status", r, 32'h04);
      bus_rd(2'd3, r); check("rst_baud", r, 32'd433);
      bus_rd(2'd0, r); check("rst_ctrl", r, 32'd0);

      // ---- asynchronous reset mid-frame ----
      bus_wr(2'd3, 32'd3);
      bus_wr(2'd0, 32'd1);
      bus_wr(2'd2, 32'h5A);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx", {31'd0, tx_out}, 32'd1);
      check("async_rst_irq", {31'd0, irq_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_rd(2'd1, r); check("midrst_status", r, 32'h04);
      bus_rd(2'd3, r); check("midrst_baud", r, 32'd433);
      bus_rd(2'd0, r); check("midrst_ctrl", r, 32'd0);

      // ---- single byte 0xA5 at div=3 ----
      mon_en = 1'b1;
      cur_div = 3;
      bus_wr(2'd3, 32'd3);
      bus_wr(2'd0, 32'd1);
      bus_wr(2'd2, 32'hA5);
      c0 = cyc;
      expect_byte(8'hA5, -1, c0 + 1);
      @(negedge clk);
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         bus_rd(2'd1, r);
         if (!r[0]) begin
            done = 1'b1;
            check("busy_clear_cycles", cyc - c0, 32'd41);
         end
      end
      if (!done) fail_msg("busy_clear");
      check("irq_disabled", {31'd0, irq_out}, 32'd0);
      wait_drain();

      // ---- FIFO fill, overflow, then full push with same-edge pop ----
      bus_wr(2'd0, 32'd0);
      for (int i = 1; i <= 5; i++) bus_wr(2'd2, i);
      bus_rd(2'd1, r); check("fill_status", r, 32'h4A);
      bus_wr(2'd1, 32'h08);
      bus_rd(2'd1, r); check("ovf_clear", r, 32'h42);
      bus_wr(2'd0, 32'd1);
      c0 = cyc;
      bus_wr(2'd2, 32'h77);
      expect_byte(8'h01, -1, c0 + 1);
      expect_byte(8'h02, 41, -1);
      expect_byte(8'h03, 41, -1);
      expect_byte(8'h04, 41, -1);
      expect_byte(8'h77, 41, -1);
      bus_rd(2'd1, r); check("full_push_pop_status", r, 32'h43);
      wait_drain();

      // ---- interrupt and clearing tx_en mid-frame ----
      bus_wr(2'd0, 32'd3);
      repeat (2) @(negedge clk);
      check("irq_idle", {31'd0, irq_out}, 32'd1);
      bus_wr(2'd2, 32'hC3);
      c0 = cyc;
      expect_byte(8'hC3, -1, c0 + 1);
      @(negedge clk);
      check("irq_before_pop", {31'd0, irq_out}, 32'd1);
      @(negedge clk);
      check("irq_after_pop", {31'd0, irq_out}, 32'd0);
      repeat (8) @(negedge clk);
      bus_wr(2'd0, 32'd2);
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (irq_out) begin
            done = 1'b1;
            check("irq_rise_cycles", cyc - c0, 32'd42);
         end
      end
      if (!done) fail_msg("irq_rise");
      bus_wr(2'd2, 32'h99);
      repeat (30) @(negedge clk);
      bus_rd(2'd1, r); check("txen_off_hold", r, 32'h10);
      check("irq_not_empty", {31'd0, irq_out}, 32'd0);

      // ---- div = 0: 1-cycle bits, 11-cycle frame period ----
      wait_drain();
      cur_div = 0;
      bus_wr(2'd3, 32'd0);
      bus_wr(2'd0, 32'd1);
      c0 = cyc;
      expect_byte(8'h99, -1, c0 + 1);
      bus_wr(2'd2, 32'h3C);
      expect_byte(8'h3C, 11, -1);
      wait_drain();

      // ---- bus isolation ----
      bus_wr(2'd0, 32'd0);
      @(negedge clk);
      sel = SelectAsNone; addr = 32'h8; wdata = 32'h55; rw = 1'b1;
      #1 check("iso_data_out", data_out, 32'd0);
      @(posedge clk);
      #1 rw = 1'b0;
      bus_rd(2'd1, r); check("iso_status", r, 32'h04);
      bus_rd(2'd2, r); check("txdata_read", r, 32'd0);

      repeat (50) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/per_uart.md
# per_uart

Transmit-only UART peripheral that sits downstream of `xSimBus` as a slave device. It decodes register accesses from the bus (`select_as_in`, `addr_in`, `data_in`, `rw_in`), buffers bytes written by the core in a small FIFO, and serializes them on `tx_out` as 8N1 frames. It gives the SoC its first real output path beyond `led_out`.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of two, ≥2.
- `DEFAULT_DIV`, 16'd433: reset value of BAUD_DIV. 433 gives 115200 baud at 50 MHz.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `select_as_in`  in  `SelectModeBus`  bus selection mode; register accesses happen only when it equals `SelectAsDevice`.
- `addr_in`  in  32  byte address from `bus_device_addr`; only `addr_in[3:2]` is decoded.
- `data_in`  in  32  write data from the bus.
- `data_out`  out  32  read data to the bus.
- `rw_in`  in  1  `RWInoutW` = write, `RWInoutR` = read.
- `tx_out`  out  1  serial line; idles high.
- `irq_out`  out  1  level interrupt: TX drained.

## Operation
- Registers, selected by `addr_in[3:2]`:
  - 0 CTRL (RW): bit0 `tx_en`, bit1 `irq_en`. Other bits read 0.
  - 1 STATUS (RO except bit3):
    - bit0 `busy` (FSM not IDLE)
    - bit1 `full`
    - bit2 `empty`
    - bit3 `ovf`, sticky; write 1 to clear
    - bits[7:4] `count`, FIFO occupancy
  - 2 TXDATA (WO): a write pushes `data_in[7:0]`. Reads return 0.
  - 3 BAUD_DIV (RW): bits[15:0] `div`. Each bit period is `div+1` cycles.
- Write: when `select_as_in==SelectAsDevice` and `rw_in==RWInoutW`, the register updates on that clock edge.
- Read: when `select_as_in==SelectAsDevice` and `rw_in==RWInoutR`, `data_out` is the combinational register value. Otherwise `data_out` = `ZeroWord`.
- FIFO behaviour:
  - Circular buffer with wrapping read/write pointers and a count of width $clog2(FIFO_DEPTH)+1.
  - Push while full with no same-cycle pop: byte is dropped and `ovf` is set.
  - Push and pop in the same cycle while full: both take effect and count is unchanged.
  - Push while empty and idle: the byte is visible to the FSM on the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when `tx_en` and FIFO not empty. On the same edge: pop the byte into an 8-bit shift register, load the bit counter with `div`, set bit index to 0.
  - START: drive `tx_out`=0. Move to DATA when the bit counter reaches 0.
  - DATA: drive `tx_out`=`shift[0]`, LSB first. At each bit end, shift right and increment the index. After bit index 7 ends, move to STOP.
  - STOP: drive `tx_out`=1. At bit end, move to IDLE.
  - The bit counter reloads from the current `div` at every bit start, so a BAUD_DIV write takes effect at the next bit boundary.
- Clearing `tx_en` mid-frame: the frame in flight completes. No new frame starts.
- `irq_out` = `irq_en & empty & ~busy`, registered.

## Timing
- Reset values:
  - `tx_out`=1, `irq_out`=0, `data_out`=0
  - CTRL=0, BAUD_DIV=`DEFAULT_DIV`, FIFO empty, `ovf`=0, FSM=IDLE
- Reset asserted mid-frame: `tx_out` goes to 1 immediately (asynchronous) and the FIFO contents are discarded.
- Start latency: TXDATA write at edge N with FSM idle and `tx_en`=1. FSM enters START at edge N+1, and `tx_out` falls right after edge N+1.
- Frame length: 10·(div+1) cycles from the START entry edge to the IDLE entry edge.
- Back-to-back frames:
  - There is exactly one IDLE cycle between a STOP bit and the next START.
  - Inter-frame period is 10·(div+1)+1 cycles.
- `tx_out` is registered and glitch-free.
- STATUS reads reflect state before the current edge.
- `irq_out` lags the condition by one cycle.
- `div`=0 is legal: 1-cycle bits, 11-cycle frame period.

## Test plan
- Reset: assert `rst` asynchronously mid-frame → `tx_out`=1, `irq_out`=0, STATUS reads 0x04, BAUD_DIV reads 433.
- Single byte: set BAUD_DIV=3, CTRL=1, write TXDATA=0xA5.
  - Required `tx_out` from edge N+1: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - `busy` clears 40 cycles after START.
- FIFO fill: with `tx_en`=0, write 5 bytes 0x01..0x05.
  - STATUS shows `count`=4, `full`=1, `ovf`=1.
  - Write STATUS with bit3=1 → `ovf`=0.
  - Set `tx_en`=1 → 0x01..0x04 are sent in order, 41 cycles apart at `div`=3.
- Full push with simultaneous pop: with FIFO full and the FSM popping on the same edge, write 0x77 → accepted, `ovf` stays 0, and 0x77 is transmitted last.
- Interrupt and enable: set CTRL=3 and send one byte → `irq_out` falls one cycle after the pop and rises one cycle after STOP ends. Clearing `tx_en` during DATA still completes the frame.
- Bus isolation: with `select_as_in`=`SelectAsNone`, issue a write to TXDATA → FIFO unchanged and `data_out`=0.
